// File: rtl/sort_job_sequencer.sv
// Job sequencer: fills the sort RAM from an input stream, hands the RAM port to the
// sorter, then drains the sorted array. Optional SORT watchdog via SORT_TIMEOUT_EN.
module sort_job_sequencer #(
  parameter int unsigned N           = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sort_start,
  input  logic              sort_done,
  input  logic [ADDR_W-1:0] srt_addr,
  input  logic              srt_we,
  input  logic [DATA_W-1:0] srt_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              sort_err
);

  typedef enum logic [2:0] {IDLE, FILL, START, SORT, RD, CAP, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_nx;
  logic [ADDR_W-1:0] rd_cnt, rd_cnt_nx;
  logic [DATA_W-1:0] out_q;
  logic              done_q;
  logic              timeout_hit;

`ifdef SORT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_cnt;

  // Held at zero outside SORT, so every SORT entry starts counting from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tmo_cnt <= '0;
    else if (state != SORT)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign timeout_hit = (state == SORT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_cnt <= wr_cnt_nx;
      rd_cnt <= rd_cnt_nx;
      done_q <= sort_done;
      if (state == CAP)
        out_q <= ram_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    wr_cnt_nx  = wr_cnt;
    rd_cnt_nx  = rd_cnt;
    in_ready   = 1'b0;
    sort_start = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    sort_err   = 1'b0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    case (state)
      IDLE, FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_addr  = wr_cnt;
          ram_we    = 1'b1;
          ram_wdata = in_data;
          if (wr_cnt == LAST_ADDR) begin
            wr_cnt_nx = '0;
            state_nx  = START;
          end else begin
            wr_cnt_nx = wr_cnt + ADDR_W'(1);
            state_nx  = FILL;
          end
        end
      end
      START: begin
        sort_start = 1'b1;
        state_nx   = SORT;
      end
      SORT: begin
        ram_addr  = srt_addr;
        ram_we    = srt_we;
        ram_wdata = srt_wdata;
        // A done edge in the same cycle as watchdog expiry takes priority.
        if (sort_done && !done_q) begin
          state_nx = RD;
        end else if (timeout_hit) begin
          sort_err = 1'b1;
          state_nx = IDLE;
        end
      end
      RD: begin
        ram_addr = rd_cnt;
        state_nx = CAP;
      end
      CAP: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == LAST_ADDR);
        if (out_ready) begin
          if (rd_cnt == LAST_ADDR) begin
            rd_cnt_nx = '0;
            state_nx  = IDLE;
          end else begin
            rd_cnt_nx = rd_cnt + ADDR_W'(1);
            state_nx  = RD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_data = out_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sort_job_sequencer.sv
// Bench for sort_job_sequencer with a behavioural sync-read RAM and a behavioural
// sorter that writes the sorted array back through the sorter port.
module tb_sort_job_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] in_data, out_data;
  logic       sort_start, sort_done, srt_we, ram_we, busy, sort_err;
  logic [3:0] srt_addr, ram_addr;
  logic [7:0] srt_wdata, ram_wdata, ram_rdata;

  logic [7:0] mem [16];
  int         srt_mode;   // 0 sorter, 1 done low, 2 done stuck high, 3 noise on srt_*
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sort_job_sequencer #(.N(8), .DATA_W(8), .ADDR_W(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sort_start(sort_start), .sort_done(sort_done),
    .srt_addr(srt_addr), .srt_we(srt_we), .srt_wdata(srt_wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .sort_err(sort_err)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Behavioural sorter: snapshot RAM, sort, write back over the sorter port, raise done.
  initial begin : sorter_p
    logic [7:0] sq[$];
    logic       st;
    srt_addr = '0; srt_we = 1'b0; srt_wdata = '0; sort_done = 1'b0;
    forever begin
      @(posedge clk);
      st = sort_start;
      #1;
      if (srt_mode == 1) sort_done = 1'b0;
      if (srt_mode == 2) sort_done = 1'b1;
      if (srt_mode == 3) begin
        srt_we = 1'b1; srt_addr = 4'($urandom_range(0, 15)); srt_wdata = 8'($urandom);
      end else begin
        srt_we = 1'b0;
      end
      if (srt_mode == 0 && st) begin
        sort_done = 1'b0;
        sq = {};
        for (int i = 0; i < N; i++) sq.push_back(mem[i]);
        sq.sort();
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < N; i++) begin
          srt_addr = 4'(i); srt_we = 1'b1; srt_wdata = sq[i];
          @(posedge clk); #1;
        end
        srt_we = 1'b0;
        sort_done = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; leaves the DUT in START after the final beat.
  task automatic fill(input logic [7:0] d[$], input bit gaps);
    for (int i = 0; i < d.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_no_write", ram_we, 0);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
      chk("beat_we", ram_we, 1);
      chk("beat_addr", ram_addr, i);
      chk("beat_wdata", ram_wdata, d[i]);
      chk("beat_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] exp[$], input bit stall);
    logic [7:0] held;
    int w;
    for (int k = 0; k < N; k++) begin
      out_ready = 1'b0;
      w = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      chk("drain_valid", out_valid, 1);
      if (stall && k == 2) begin
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, held);
        end
      end
      chk("out_data", out_data, exp[k]);
      chk("out_last", out_last, (k == N - 1));
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_done;
    int w = 0;
    while (sort_done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    chk("sort_done_seen", sort_done, 1);
  endtask

  initial begin : main_p
    logic [7:0] dq[$];
    logic [7:0] eq[$];
    int c;
    srt_mode = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_sort_start", sort_start, 0);
    chk("idle_ram_we", ram_we, 0);
    chk("idle_sort_err", sort_err, 0);

    // Directed job
    @(posedge clk); #1;
    dq = {8'd7, 8'd3, 8'd5, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    fill(dq, 1'b0);
    @(negedge clk);
    chk("start_pulse", sort_start, 1);
    chk("start_in_ready", in_ready, 0);
    @(negedge clk);
    chk("start_one_cycle", sort_start, 0);
    chk("sort_busy", busy, 1);
    wait_done();
    @(negedge clk); chk("lat_rd", out_valid, 0);
    @(negedge clk); chk("lat_cap", out_valid, 0);
    @(negedge clk); chk("lat_out", out_valid, 1);
    eq = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    drain(eq, 1'b0);
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_in_ready", in_ready, 1);

    // Random job with input gaps, sorter-port noise during fill, and an output stall
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      dq = {};
      for (int i = 0; i < N; i++) dq.push_back(8'($urandom_range(0, 255)));
      eq = dq;
      eq.sort();
      srt_mode = 3;
      fill(dq, 1'b1);
      srt_mode = 0;
      @(negedge clk);
      chk("rnd_start", sort_start, 1);
      wait_done();
      drain(eq, (r == 0));
      @(negedge clk);
      chk("rnd_end_busy", busy, 0);
    end

    // sort_done already high before SORT: no edge, job never completes
    @(posedge clk); #1;
    srt_mode = 2;
    dq = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    fill(dq, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("stuck_busy", busy, 1);
      chk("stuck_no_out", out_valid, 0);
    end
    // Reset in SORT aborts at once
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_sort_start", sort_start, 0);
    chk("abort_out_valid", out_valid, 0);
    srt_mode = 1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_out", out_valid, 0);
      chk("post_abort_busy", busy, 0);
    end

    // Watchdog: sort_done held low
    @(posedge clk); #1;
    fill(dq, 1'b0);
    @(negedge clk);
`ifdef SORT_TIMEOUT_EN
    c = 0;
    do begin
      @(negedge clk);
      c++;
      chk("tmo_no_out", out_valid, 0);
    end while (sort_err !== 1'b1 && c < 40);
    chk("tmo_cycle", c, 16);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_err_pulse", sort_err, 0);
    chk("tmo_out_valid", out_valid, 0);
`else
    c = 0;
    repeat (40) begin
      @(negedge clk);
      if (sort_err === 1'b1) c++;
    end
    chk("no_tmo_err", c, 0);
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_out", out_valid, 0);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog_p
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end

endmodule
